// File: rtl/dft8_pkg.sv
// Shared constants, state encoding and constant tables for the 8-point DFT engine.
// The optional Hann window (macro DFT8_HANN_WINDOW_EN) draws its coefficients from here.
package dft8_pkg;

    localparam int SAMPLE_W  = 32;
    localparam int TWID_W    = 32;
    localparam int TWID_FRAC = 30;
    localparam int ACC_W     = SAMPLE_W + TWID_W + 3;
    localparam int DFT_N     = 8;
    localparam int NUM_BINS  = 5;

    localparam logic signed [TWID_W-1:0] TWID_ONE = 32'sd1073741824;
    localparam logic signed [TWID_W-1:0] TWID_R   = 32'sd759250125;

    typedef enum logic {FILL, COMPUTE} state_t;

    // cos(2*pi*m/8) in Q2.30
    function automatic logic signed [TWID_W-1:0] cos_tw(input logic [2:0] m);
        case (m)
            3'd0: return TWID_ONE;
            3'd1: return TWID_R;
            3'd2: return '0;
            3'd3: return -TWID_R;
            3'd4: return -TWID_ONE;
            3'd5: return -TWID_R;
            3'd6: return '0;
            3'd7: return TWID_R;
        endcase
    endfunction

    // sin(2*pi*m/8) in Q2.30
    function automatic logic signed [TWID_W-1:0] sin_tw(input logic [2:0] m);
        case (m)
            3'd0: return '0;
            3'd1: return TWID_R;
            3'd2: return TWID_ONE;
            3'd3: return TWID_R;
            3'd4: return '0;
            3'd5: return -TWID_R;
            3'd6: return -TWID_ONE;
            3'd7: return -TWID_R;
        endcase
    endfunction

    // Periodic Hann window, unsigned Q1.16
    function automatic logic [16:0] hann_coef(input logic [2:0] n);
        case (n)
            3'd0: return 17'd0;
            3'd1: return 17'd9598;
            3'd2: return 17'd32768;
            3'd3: return 17'd55938;
            3'd4: return 17'd65536;
            3'd5: return 17'd55938;
            3'd6: return 17'd32768;
            3'd7: return 17'd9598;
        endcase
    endfunction

endpackage

// File: rtl/dft8_if.sv
// Sample stream and bin result bus of the 8-point DFT engine.
interface dft8_if;
    import dft8_pkg::*;

    logic signed [SAMPLE_W-1:0] s_data;
    logic                       s_valid;
    logic                       s_ready;
    logic signed [ACC_W-1:0]    out_real0, out_real1, out_real2, out_real3, out_real4;
    logic signed [ACC_W-1:0]    out_imag0, out_imag1, out_imag2, out_imag3, out_imag4;
    logic                       out_valid;
    logic                       busy;

    modport master (
        output s_data, s_valid,
        input  s_ready, out_valid, busy,
        input  out_real0, out_real1, out_real2, out_real3, out_real4,
        input  out_imag0, out_imag1, out_imag2, out_imag3, out_imag4
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, out_valid, busy,
        output out_real0, out_real1, out_real2, out_real3, out_real4,
        output out_imag0, out_imag1, out_imag2, out_imag3, out_imag4
    );

endinterface

// File: rtl/dft8_mac.sv
// Cos/sin multiply-accumulate pair; o_sum_* is the running sum including the current product.
module dft8_mac
    import dft8_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_clr,
    input  logic                       i_en,
    input  logic                       i_last,
    input  logic signed [SAMPLE_W-1:0] i_sample,
    input  logic signed [TWID_W-1:0]   i_cos,
    input  logic signed [TWID_W-1:0]   i_sin,
    output logic signed [ACC_W-1:0]    o_sum_re,
    output logic signed [ACC_W-1:0]    o_sum_im
);

    localparam int PROD_W = SAMPLE_W + TWID_W;

    logic signed [PROD_W-1:0] w_prod_re;
    logic signed [PROD_W-1:0] w_prod_im;
    logic signed [ACC_W-1:0]  r_acc_re;
    logic signed [ACC_W-1:0]  r_acc_im;

    assign w_prod_re = PROD_W'(i_sample) * PROD_W'(i_cos);
    assign w_prod_im = PROD_W'(i_sample) * PROD_W'(i_sin);
    assign o_sum_re  = r_acc_re + ACC_W'(w_prod_re);
    assign o_sum_im  = r_acc_im - ACC_W'(w_prod_im);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_acc_re <= '0;
            r_acc_im <= '0;
        end else if (i_en) begin
            // The final sum is taken by the top on i_last; restart the bin from zero.
            r_acc_re <= i_last ? '0 : o_sum_re;
            r_acc_im <= i_last ? '0 : o_sum_im;
        end
    end

endmodule

// File: rtl/dft8_engine.sv
// Streaming 8-point real DFT: fills 8 samples, then computes bins 0..4 over 40 cycles.
// Define DFT8_HANN_WINDOW_EN to apply a periodic Hann window as samples are stored.
module dft8_engine
    import dft8_pkg::*;
(
    input logic   clk,
    input logic   rst_n,
    dft8_if.slave bus
);

    state_t                     r_state;
    state_t                     w_next_state;
    logic [2:0]                 r_idx;
    logic [5:0]                 r_cnt;
    logic signed [SAMPLE_W-1:0] r_buf [DFT_N];
    logic signed [ACC_W-1:0]    r_out_re [NUM_BINS];
    logic signed [ACC_W-1:0]    r_out_im [NUM_BINS];
    logic                       r_out_valid;

    logic                       w_ready;
    logic                       w_busy;
    logic                       w_accept;
    logic [2:0]                 w_k;
    logic [2:0]                 w_n;
    logic [2:0]                 w_m;
    logic                       w_last_n;
    logic                       w_last_c;
    logic signed [SAMPLE_W-1:0] w_store;
    logic signed [ACC_W-1:0]    w_sum_re;
    logic signed [ACC_W-1:0]    w_sum_im;

    assign w_accept = bus.s_valid && w_ready;
    assign w_k      = r_cnt[5:3];
    assign w_n      = r_cnt[2:0];
    assign w_m      = w_k * w_n;
    assign w_last_n = (w_n == 3'd7);
    assign w_last_c = (r_cnt == 6'd39);

`ifdef DFT8_HANN_WINDOW_EN
    localparam int WIN_W = SAMPLE_W + 18;
    logic signed [WIN_W-1:0] w_win_prod;
    assign w_win_prod = WIN_W'(bus.s_data) * WIN_W'($signed({1'b0, hann_coef(r_idx)}));
    assign w_store    = w_win_prod[SAMPLE_W+15:16];
`else
    assign w_store = bus.s_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= FILL;
        else        r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            FILL:    if (w_accept && r_idx == 3'd7) w_next_state = COMPUTE;
            COMPUTE: if (w_last_c)                  w_next_state = FILL;
            default: w_next_state = FILL;
        endcase
    end

    always_comb begin
        w_ready = (r_state == FILL);
        w_busy  = (r_state == COMPUTE);
    end

    // NOTE: the sample buffer has no reset; every entry is rewritten before COMPUTE reads it.
    always_ff @(posedge clk) begin
        if (w_accept) r_buf[r_idx] <= w_store;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            for (int k = 0; k < NUM_BINS; k++) begin
                r_out_re[k] <= '0;
                r_out_im[k] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept) r_idx <= r_idx + 3'd1;
            if (w_busy) begin
                r_cnt <= w_last_c ? 6'd0 : r_cnt + 6'd1;
                if (w_last_n) begin
                    r_out_re[w_k] <= w_sum_re;
                    r_out_im[w_k] <= w_sum_im;
                end
                if (w_last_c) r_out_valid <= 1'b1;
            end
        end
    end

    dft8_mac u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_ready),
        .i_en     (w_busy),
        .i_last   (w_last_n),
        .i_sample (r_buf[w_n]),
        .i_cos    (cos_tw(w_m)),
        .i_sin    (sin_tw(w_m)),
        .o_sum_re (w_sum_re),
        .o_sum_im (w_sum_im)
    );

    assign bus.s_ready   = w_ready;
    assign bus.busy      = w_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.out_real0 = r_out_re[0];
    assign bus.out_real1 = r_out_re[1];
    assign bus.out_real2 = r_out_re[2];
    assign bus.out_real3 = r_out_re[3];
    assign bus.out_real4 = r_out_re[4];
    assign bus.out_imag0 = r_out_im[0];
    assign bus.out_imag1 = r_out_im[1];
    assign bus.out_imag2 = r_out_im[2];
    assign bus.out_imag3 = r_out_im[3];
    assign bus.out_imag4 = r_out_im[4];

endmodule

// File: tb/tb_dft8_engine.sv
// Directed vector bench for dft8_engine: bin values, latency, backpressure, mid-compute reset.
module tb_dft8_engine;
    import dft8_pkg::*;

    typedef struct packed {
        logic [7:0][31:0] x;
        logic [4:0][66:0] re;
        logic [4:0][66:0] im;
        logic             gaps;
    } vec_t;

    localparam int NV = 6;
    localparam logic signed [66:0] ONE_Q = 67'sd1073741824;
    localparam logic signed [66:0] R_Q   = 67'sd759250125;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs [NV];

    dft8_if u_if();

    dft8_engine u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [66:0] act, input logic signed [66:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [66:0] get_re(input int k);
        case (k)
            0: return u_if.out_real0;
            1: return u_if.out_real1;
            2: return u_if.out_real2;
            3: return u_if.out_real3;
            4: return u_if.out_real4;
            default: return '0;
        endcase
    endfunction

    function automatic logic signed [66:0] get_im(input int k);
        case (k)
            0: return u_if.out_imag0;
            1: return u_if.out_imag1;
            2: return u_if.out_imag2;
            3: return u_if.out_imag3;
            4: return u_if.out_imag4;
            default: return '0;
        endcase
    endfunction

    // Presents the frame from the current negedge; e0 is the cycle count of the 8th accept edge.
    task automatic send_frame(input vec_t v, output int e0);
        int   i;
        int   guard;
        logic acc;
        i     = 0;
        guard = 0;
        while (i < 8 && guard < 200) begin
            if (v.gaps && $urandom_range(0, 1) == 1) begin
                u_if.s_valid = 1'b0;
                u_if.s_data  = 32'h5a5a5a5a;
            end else begin
                u_if.s_valid = 1'b1;
                u_if.s_data  = v.x[i];
            end
            acc = u_if.s_valid && u_if.s_ready;
            @(negedge clk);
            if (acc) i++;
            guard++;
        end
        e0 = cyc;
        check("fill_accepts", i, 8);
    endtask

    // Runs one frame, keeping s_valid high with junk through COMPUTE; returns at the out_valid negedge.
    task automatic run_vector(input int vi);
        int e0;
        int waited;
        bit ok_bp;
        send_frame(vecs[vi], e0);
        u_if.s_valid = 1'b1;
        u_if.s_data  = 32'sh7777;
        ok_bp  = 1'b1;
        waited = 0;
        while (u_if.out_valid !== 1'b1 && waited < 100) begin
            if (u_if.s_ready !== 1'b0 || u_if.busy !== 1'b1) ok_bp = 1'b0;
            @(negedge clk);
            waited++;
        end
        check($sformatf("v%0d_ready_low_busy_high", vi), ok_bp, 1);
        check($sformatf("v%0d_latency", vi), cyc - e0, 40);
        check($sformatf("v%0d_ready_at_valid", vi), u_if.s_ready, 1);
        check($sformatf("v%0d_busy_at_valid", vi), u_if.busy, 0);
        for (int k = 0; k < NUM_BINS; k++) begin
            check($sformatf("v%0d_re%0d", vi, k), get_re(k), $signed(vecs[vi].re[k]));
            check($sformatf("v%0d_im%0d", vi, k), get_im(k), $signed(vecs[vi].im[k]));
        end
    endtask

    initial begin
        int  e0;
        bit  seen;
        bit  zero_ok;

        for (int i = 0; i < NV; i++) vecs[i] = '0;
        // DC 1000
        for (int n = 0; n < 8; n++) vecs[0].x[n] = 32'sd1000;
        vecs[0].re[0] = 8000 * ONE_Q;
        // impulse 5, with random valid gaps
        vecs[1].x[0] = 32'sd5;
        for (int k = 0; k < 5; k++) vecs[1].re[k] = 5 * ONE_Q;
        vecs[1].gaps = 1'b1;
        // bin-2 cosine
        vecs[2].x[0] = 32'sd1000;  vecs[2].x[2] = -32'sd1000;
        vecs[2].x[4] = 32'sd1000;  vecs[2].x[6] = -32'sd1000;
        vecs[2].re[2] = 4000 * ONE_Q;
        // bin-2 sine
        vecs[3].x[1] = 32'sd1000;  vecs[3].x[3] = -32'sd1000;
        vecs[3].x[5] = 32'sd1000;  vecs[3].x[7] = -32'sd1000;
        vecs[3].im[2] = -4000 * ONE_Q;
        // delayed impulse 1000 at n=1: exercises the sqrt(2)/2 twiddles
        vecs[4].x[1] = 32'sd1000;
        vecs[4].re[0] = 1000 * ONE_Q;   vecs[4].im[0] = '0;
        vecs[4].re[1] = 1000 * R_Q;     vecs[4].im[1] = -1000 * R_Q;
        vecs[4].re[2] = '0;             vecs[4].im[2] = -1000 * ONE_Q;
        vecs[4].re[3] = -1000 * R_Q;    vecs[4].im[3] = -1000 * R_Q;
        vecs[4].re[4] = -1000 * ONE_Q;  vecs[4].im[4] = '0;
        // most negative DC: -2^31 * 8 * 2^30 = -2^64, with gaps
        for (int n = 0; n < 8; n++) vecs[5].x[n] = 32'sh80000000;
        vecs[5].re[0] = -(ONE_Q <<< 34);
        vecs[5].gaps  = 1'b1;

        u_if.s_valid = 1'b0;
        u_if.s_data  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_s_ready", u_if.s_ready, 1);
        check("rst_out_valid", u_if.out_valid, 0);
        check("rst_busy", u_if.busy, 0);
        check("rst_out_real0", u_if.out_real0, 0);
        check("rst_out_imag4", u_if.out_imag4, 0);

        // back-to-back frames: each next frame starts at the out_valid negedge
        for (int vi = 0; vi < NV; vi++) run_vector(vi);
        u_if.s_valid = 1'b0;
        @(negedge clk);
        check("out_valid_one_cycle", u_if.out_valid, 0);
        check("idle_ready", u_if.s_ready, 1);

        // reset while c=20 is the next step
        send_frame(vecs[0], e0);
        u_if.s_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_reset_busy", u_if.busy, 1);
        check("pre_reset_bin0", u_if.out_real0, 8000 * ONE_Q);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        zero_ok = 1'b1;
        for (int k = 0; k < NUM_BINS; k++)
            if (get_re(k) !== '0 || get_im(k) !== '0) zero_ok = 1'b0;
        check("reset_outputs_zero", zero_ok, 1);
        check("reset_busy", u_if.busy, 0);
        check("reset_s_ready", u_if.s_ready, 1);
        seen = 1'b0;
        repeat (50) begin
            if (u_if.out_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        check("reset_no_out_valid", seen, 0);
        check("reset_bin0_still_zero", u_if.out_real0, 0);

        run_vector(0);
        u_if.s_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
